serial_to_parallel_framer: RTL and testbench

Downstream companion to the team's parallel-in/serial-out shifter. Collects an LSB-first serial bit stream into DATA_WIDTH-bit words, framed by a start strobe aligned with bit 0. Presents each completed word on a registered parallel output with a valid/ready handshake. Flags aborted frames and output overruns.

---
 rtl/serial_to_parallel_framer.sv | 129 ++++++++++++
 tb/tb_serial_to_parallel_framer.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/serial_to_parallel_framer.sv
// LSB-first serial-to-parallel framer: word registered DATA_WIDTH-1 edges after its frame_start.
// Output is valid/ready; a completion while the word is unconsumed overwrites it and pulses overrun.
module serial_to_parallel_framer #(
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  din,
    input  logic                  frame_start,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  dout_valid,
    input  logic                  dout_ready,
    output logic                  frame_err,
    output logic                  overrun
);

    localparam int CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(DATA_WIDTH - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [DATA_WIDTH-1:0] r_sr;
    logic [DATA_WIDTH-1:0] w_sr_nxt;
    logic [DATA_WIDTH-1:0] w_shifted;
    logic [DATA_WIDTH-1:0] w_restart;
    logic [DATA_WIDTH:0]   w_cat;
    logic [CW-1:0]         r_cnt;
    logic [CW-1:0]         w_cnt_nxt;
    logic                  w_complete;
    logic                  w_ferr_nxt;
    logic [DATA_WIDTH-1:0] r_dout;
    logic                  r_dout_valid;
    logic                  r_frame_err;
    logic                  r_overrun;

    // Concatenate-then-drop keeps the shift legal for DATA_WIDTH=1.
    assign w_cat     = {din, r_sr};
    assign w_shifted = w_cat[DATA_WIDTH:1];
    assign w_restart = DATA_WIDTH'(din) << (DATA_WIDTH - 1);

    always_comb begin
        w_state_nxt = r_state;
        w_sr_nxt    = r_sr;
        w_cnt_nxt   = r_cnt;
        w_complete  = 1'b0;
        w_ferr_nxt  = 1'b0;
        case (r_state)
            IDLE: begin
                if (frame_start) begin
                    w_sr_nxt = w_restart;
                    if (DATA_WIDTH == 1) begin
                        w_complete = 1'b1;
                    end else begin
                        w_cnt_nxt   = CW'(1);
                        w_state_nxt = SHIFT;
                    end
                end
            end
            SHIFT: begin
                if (frame_start) begin
                    w_ferr_nxt = 1'b1;
                    w_sr_nxt   = w_restart;
                    if (DATA_WIDTH == 1) begin
                        w_complete  = 1'b1;
                        w_cnt_nxt   = '0;
                        w_state_nxt = IDLE;
                    end else begin
                        w_cnt_nxt = CW'(1);
                    end
                end else begin
                    w_sr_nxt = w_shifted;
                    if (r_cnt == LAST) begin
                        w_complete  = 1'b1;
                        w_cnt_nxt   = '0;
                        w_state_nxt = IDLE;
                    end else begin
                        w_cnt_nxt = r_cnt + CW'(1);
                    end
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= IDLE;
            r_sr    <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_sr    <= w_sr_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // On completion w_sr_nxt already holds the finished word.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_dout       <= '0;
            r_dout_valid <= 1'b0;
            r_frame_err  <= 1'b0;
            r_overrun    <= 1'b0;
        end else begin
            r_frame_err <= w_ferr_nxt;
            r_overrun   <= w_complete && r_dout_valid && !dout_ready;
            if (w_complete) begin
                r_dout       <= w_sr_nxt;
                r_dout_valid <= 1'b1;
            end else if (r_dout_valid && dout_ready) begin
                r_dout_valid <= 1'b0;
            end
        end
    end

    assign dout       = r_dout;
    assign dout_valid = r_dout_valid;
    assign frame_err  = r_frame_err;
    assign overrun    = r_overrun;

endmodule

// File: tb/tb_serial_to_parallel_framer.sv
// Directed and random stimulus for 8-bit and 1-bit framers, checked against a bit-list model.
module tb_serial_to_parallel_framer;

    logic       clk;
    logic       resetn;
    logic       din8, fs8, rdy8;
    logic [7:0] dout8;
    logic       vld8, ferr8, ovr8;
    logic       din1, fs1, rdy1;
    logic [0:0] dout1;
    logic       vld1, ferr1, ovr1;

    int n_vec = 0;
    int n_err = 0;

    // Model state per instance: index 0 = 8-bit, index 1 = 1-bit.
    int          m_w    [2];
    int          m_n    [2];
    logic [63:0] m_acc  [2];
    logic [63:0] m_dout [2];
    logic        m_vld  [2];
    logic        m_ferr [2];
    logic        m_ovr  [2];

    serial_to_parallel_framer #(.DATA_WIDTH(8)) dut8 (
        .clk(clk), .resetn(resetn), .din(din8), .frame_start(fs8),
        .dout(dout8), .dout_valid(vld8), .dout_ready(rdy8),
        .frame_err(ferr8), .overrun(ovr8)
    );

    serial_to_parallel_framer #(.DATA_WIDTH(1)) dut1 (
        .clk(clk), .resetn(resetn), .din(din1), .frame_start(fs1),
        .dout(dout1), .dout_valid(vld1), .dout_ready(rdy1),
        .frame_err(ferr1), .overrun(ovr1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_n[i] = 0; m_acc[i] = '0; m_dout[i] = '0;
            m_vld[i] = 1'b0; m_ferr[i] = 1'b0; m_ovr[i] = 1'b0;
        end
    endtask

    // A frame is the list of bits since the last frame_start; it completes at m_w bits.
    task automatic model_step(input int i, input logic fs, input logic d, input logic rdy);
        logic done;
        done = 1'b0;
        m_ferr[i] = 1'b0;
        m_ovr[i]  = 1'b0;
        if (fs) begin
            if (m_n[i] > 0) m_ferr[i] = 1'b1;
            m_acc[i]    = '0;
            m_acc[i][0] = d;
            m_n[i]      = 1;
        end else if (m_n[i] > 0) begin
            m_acc[i][m_n[i]] = d;
            m_n[i]++;
        end
        if (m_n[i] == m_w[i]) begin
            done   = 1'b1;
            m_n[i] = 0;
        end
        if (done) begin
            m_ovr[i]  = m_vld[i] && !rdy;
            m_dout[i] = m_acc[i];
            m_vld[i]  = 1'b1;
        end else if (m_vld[i] && rdy) begin
            m_vld[i] = 1'b0;
        end
    endtask

    task automatic check_all(input string ph);
        check({ph, "_dout8"}, 64'(dout8), m_dout[0]);
        check({ph, "_vld8"},  64'(vld8),  64'(m_vld[0]));
        check({ph, "_ferr8"}, 64'(ferr8), 64'(m_ferr[0]));
        check({ph, "_ovr8"},  64'(ovr8),  64'(m_ovr[0]));
        check({ph, "_dout1"}, 64'(dout1), m_dout[1]);
        check({ph, "_vld1"},  64'(vld1),  64'(m_vld[1]));
        check({ph, "_ferr1"}, 64'(ferr1), 64'(m_ferr[1]));
        check({ph, "_ovr1"},  64'(ovr1),  64'(m_ovr[1]));
    endtask

    task automatic step(input logic f8, input logic d8, input logic r8,
                        input logic f1, input logic d1, input logic r1);
        @(negedge clk);
        fs8 = f8; din8 = d8; rdy8 = r8;
        fs1 = f1; din1 = d1; rdy1 = r1;
        @(posedge clk);
        model_step(0, f8, d8, r8);
        model_step(1, f1, d1, r1);
        #1;
        check_all("step");
    endtask

    task automatic step8(input logic f8, input logic d8, input logic r8);
        step(f8, d8, r8, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)));
    endtask

    task automatic send8(input logic [7:0] w, input logic rdy);
        for (int b = 0; b < 8; b++) step8(b == 0, w[b], rdy);
    endtask

    initial begin
        logic [7:0] w;
        m_w[0] = 8;
        m_w[1] = 1;
        model_reset();
        resetn = 1'b0;
        fs8 = 1'b0; din8 = 1'b0; rdy8 = 1'b0;
        fs1 = 1'b0; din1 = 1'b0; rdy1 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        @(negedge clk);
        resetn = 1'b1;

        // Basic word
        send8(8'hA5, 1'b1);
        check("basic_dout", 64'(dout8), 64'h00A5);
        check("basic_vld", 64'(vld8), 64'd1);
        step8(1'b0, 1'b0, 1'b1);
        check("basic_vld_clr", 64'(vld8), 64'd0);

        // Back-to-back words
        send8(8'h3C, 1'b1);
        check("b2b_first", 64'(dout8), 64'h003C);
        send8(8'hC3, 1'b1);
        check("b2b_second", 64'(dout8), 64'h00C3);
        check("b2b_vld", 64'(vld8), 64'd1);

        // Mid-frame restart
        for (int b = 0; b < 4; b++) step8(b == 0, 1'b1, 1'b1);
        w = 8'h5A;
        step8(1'b1, w[0], 1'b1);
        check("restart_ferr", 64'(ferr8), 64'd1);
        for (int b = 1; b < 8; b++) step8(1'b0, w[b], 1'b1);
        check("restart_dout", 64'(dout8), 64'h005A);
        check("restart_vld", 64'(vld8), 64'd1);

        // Backpressure and overrun
        send8(8'h11, 1'b0);
        check("bp_first", 64'(dout8), 64'h0011);
        for (int b = 0; b < 7; b++) begin
            w = 8'h22;
            step8(b == 0, w[b], 1'b0);
            check("bp_hold", 64'(dout8), 64'h0011);
        end
        step8(1'b0, 1'b0, 1'b0);
        check("bp_dout", 64'(dout8), 64'h0022);
        check("bp_ovr", 64'(ovr8), 64'd1);
        step8(1'b0, 1'b0, 1'b0);
        check("bp_ovr_once", 64'(ovr8), 64'd0);
        step8(1'b0, 1'b0, 1'b1);
        check("bp_vld_clr", 64'(vld8), 64'd0);

        // Simultaneous accept and complete
        send8(8'h44, 1'b0);
        w = 8'h99;
        for (int b = 0; b < 8; b++) step8(b == 0, w[b], b == 7);
        check("sim_dout", 64'(dout8), 64'h0099);
        check("sim_vld", 64'(vld8), 64'd1);
        check("sim_ovr", 64'(ovr8), 64'd0);

        // Asynchronous reset mid-frame
        send8(8'h77, 1'b0);
        for (int b = 0; b < 3; b++) step8(b == 0, 1'b1, 1'b0);
        #2;
        resetn = 1'b0;
        #1;
        model_reset();
        check_all("arst");
        @(negedge clk);
        resetn = 1'b1;
        send8(8'hE1, 1'b1);
        check("arst_next", 64'(dout8), 64'h00E1);

        // DATA_WIDTH=1 single-bit frame
        step(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
        check("w1_dout", 64'(dout1), 64'd1);
        check("w1_vld", 64'(vld1), 64'd1);

        // Random traffic
        for (int k = 0; k < 400; k++) begin
            step(($urandom_range(0, 9) == 0) || (m_n[0] == 0 && $urandom_range(0, 1) == 1),
                 1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
